// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access unit: control-word fields,
// access sizes, FSM states and the default ACK timeout.
package mem_pkg;

  localparam int CTRL_SZ_HI = 6;
  localparam int CTRL_SZ_LO = 5;
  localparam int CTRL_STORE = 4;
  localparam int CTRL_ADD   = 3;
  localparam int CTRL_PRE   = 2;
  localparam int CTRL_FWD   = 1;
  localparam int CTRL_WB    = 0;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_FINISH = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data replication and load
// extraction/rotation, keyed by access size and the low effective-address bits.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [31:0] wsrc_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rot_s;

  // rotate read data right by 8*ea so the addressed byte lands in bits [7:0]
  always_comb begin
    rot_s = rdata_i;
    case (ea_lo_i)
      2'd0:    rot_s = rdata_i;
      2'd1:    rot_s = {rdata_i[7:0],  rdata_i[31:8]};
      2'd2:    rot_s = {rdata_i[15:0], rdata_i[31:16]};
      2'd3:    rot_s = {rdata_i[23:0], rdata_i[31:24]};
      default: rot_s = rdata_i;
    endcase
  end

  // size 2'b11 falls through to the byte handling
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wsrc_i;
    rdata_o = rot_s;
    case (size_i)
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wsrc_i;
        rdata_o = rot_s;
      end
      SZ_HALF: begin
        be_o    = ea_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wsrc_i[15:0]}};
        rdata_o = {16'h0000, (ea_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0])};
      end
      default: begin
        be_o    = 4'b0001 << ea_lo_i;
        wdata_o = {4{wsrc_i[7:0]}};
        rdata_o = {24'h000000, rot_s[7:0]};
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: one data-memory transaction per START, with
// address generation, req/ack bus handshake, ACK timeout and load alignment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [6:0]    ctrl_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] offset_i,
  input  logic [31:0]   store_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [31:0]   load_data_o,
  output logic [AW-1:0] wb_addr_o,
  output logic          wb_en_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_ack_i
);

  localparam int             CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_s, ack_s, capture_s;

  logic [AW-1:0] sum_s, ea_s;
  logic [31:0]   src_s;

  logic [1:0]    size_q, ea_lo_q;
  logic          store_q, wb_q;
  logic [31:0]   src_q;
  logic [AW-1:0] mem_addr_q, wb_addr_q;

  logic          busy_q, done_q, err_q, wb_en_q;
  logic [31:0]   load_data_q;

  logic [3:0]    be_s;
  logic [31:0]   wdata_s, ld_align_s;

  assign capture_s = (state_q == ST_IDLE) && start_i;
  assign sum_s     = ctrl_i[CTRL_ADD] ? (base_i + offset_i) : (base_i - offset_i);
  assign ea_s      = ctrl_i[CTRL_PRE] ? sum_s : base_i;
  assign src_s     = ctrl_i[CTRL_FWD] ? load_data_q : store_data_i;

  mem_lane_align u_align (
    .size_i  (size_q),
    .ea_lo_i (ea_lo_q),
    .wsrc_i  (src_q),
    .rdata_i (mem_rdata_i),
    .be_o    (be_s),
    .wdata_o (wdata_s),
    .rdata_o (ld_align_s)
  );

  // next-state logic; the counter tracks ACCESS cycles spent without ACK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_s   = 1'b0;
    ack_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ack_i) begin
          state_d = ST_FINISH;
          ack_s   = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_FINISH;
          tmo_s   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and timeout counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // command capture; only the fields needed after acceptance are kept
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      size_q     <= 2'b00;
      ea_lo_q    <= 2'b00;
      store_q    <= 1'b0;
      wb_q       <= 1'b0;
      src_q      <= 32'h0000_0000;
      mem_addr_q <= '0;
      wb_addr_q  <= '0;
    end else if (capture_s) begin
      size_q     <= ctrl_i[CTRL_SZ_HI:CTRL_SZ_LO];
      ea_lo_q    <= ea_s[1:0];
      store_q    <= ctrl_i[CTRL_STORE];
      wb_q       <= ctrl_i[CTRL_WB];
      src_q      <= src_s;
      mem_addr_q <= {ea_s[AW-1:2], 2'b00};
      wb_addr_q  <= sum_s;
    end
  end

  // status pulses and the load result register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wb_en_q     <= 1'b0;
      load_data_q <= 32'h0000_0000;
    end else begin
      busy_q  <= (state_d == ST_ACCESS);
      done_q  <= (state_d == ST_FINISH);
      err_q   <= tmo_s;
      wb_en_q <= ack_s & wb_q;
      if (ack_s && !store_q) begin
        load_data_q <= ld_align_s;
      end
    end
  end

  // bus strobes come from registers, so reset drops them asynchronously
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wb_en_o     = wb_en_q;
  assign load_data_o = load_data_q;
  assign wb_addr_o   = wb_addr_q;
  assign mem_req_o   = busy_q;
  assign mem_we_o    = busy_q & store_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = busy_q ? be_s : 4'b0000;
  assign mem_wdata_o = busy_q ? wdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected transaction results are
// queued per command and compared when DONE is observed.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, err, wb_en, mem_req, mem_we, mem_ack;
  logic [6:0]  ctrl;
  logic [31:0] base, offset, sdata, load_data, wb_addr, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          reqs;
    int          lat;
    logic        err;
    logic        wb_en;
    logic [31:0] wb_addr;
    logic [31:0] load;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16), .AW(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .ctrl_i(ctrl),
    .base_i(base), .offset_i(offset), .store_data_i(sdata),
    .busy_o(busy), .done_o(done), .err_o(err), .load_data_o(load_data),
    .wb_addr_o(wb_addr), .wb_en_o(wb_en), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  // Drives one command, plays the memory (ACK after ack_wait REQ cycles, never if <0),
  // pulses START again at cycle poke_at, then pops the scoreboard entry and compares.
  task automatic run_cmd(input logic [6:0] c, input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] sd, input int ack_wait, input logic [31:0] rd,
                         input int poke_at);
    exp_t e;
    int cyc, reqs, lat, extra_req, extra_done;
    bit seen_done, bus_ok;
    logic [31:0] a0, w0, wba0, ld0;
    logic [3:0] be0;
    logic we0, err0, wben0;
    cyc = 0; reqs = 0; lat = -1; extra_req = 0; extra_done = 0;
    seen_done = 1'b0; bus_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; ctrl = c; base = b; offset = o; sdata = sd;
    @(negedge clk);
    cyc = 1;
    while (!seen_done && cyc < 40) begin
      start   = (cyc == poke_at);
      mem_ack = 1'b0;
      mem_rdata = 32'h0BAD_F00D;
      if (done) begin
        seen_done = 1'b1; lat = cyc;
        err0 = err; wben0 = wb_en; wba0 = wb_addr; ld0 = load_data;
        if (mem_req || busy) bus_ok = 1'b0;
      end else begin
        if (!busy || !mem_req) bus_ok = 1'b0;
        if (reqs == 0) begin
          a0 = mem_addr; be0 = mem_be; we0 = mem_we; w0 = mem_wdata;
        end else if (mem_addr !== a0 || mem_be !== be0 || mem_we !== we0 || mem_wdata !== w0) begin
          bus_ok = 1'b0;
        end
        if (reqs == ack_wait) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end
        reqs++;
        @(negedge clk);
        cyc++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cyc++;
      start   = (cyc == poke_at);
      mem_ack = 1'b0;
      if (mem_req) extra_req++;
      if (done) extra_done++;
    end
    start = 1'b0;

    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_empty: got 0 entries, required 1");
      return;
    end
    e = sb_q.pop_front();
    n_vec++; if (lat !== e.lat) begin n_err++; $display("FAIL done_latency: got %0d required %0d", lat, e.lat); end
    n_vec++; if (reqs !== e.reqs) begin n_err++; $display("FAIL req_cycles: got %0d required %0d", reqs, e.reqs); end
    n_vec++; if (a0 !== e.addr) begin n_err++; $display("FAIL mem_addr: got %h required %h", a0, e.addr); end
    n_vec++; if (be0 !== e.be) begin n_err++; $display("FAIL mem_be: got %b required %b", be0, e.be); end
    n_vec++; if (we0 !== e.we) begin n_err++; $display("FAIL mem_we: got %b required %b", we0, e.we); end
    if (e.we) begin
      n_vec++; if (w0 !== e.wdata) begin n_err++; $display("FAIL mem_wdata: got %h required %h", w0, e.wdata); end
    end
    n_vec++; if (err0 !== e.err) begin n_err++; $display("FAIL err: got %b required %b", err0, e.err); end
    n_vec++; if (wben0 !== e.wb_en) begin n_err++; $display("FAIL wb_en: got %b required %b", wben0, e.wb_en); end
    n_vec++; if (wba0 !== e.wb_addr) begin n_err++; $display("FAIL wb_addr: got %h required %h", wba0, e.wb_addr); end
    n_vec++; if (ld0 !== e.load) begin n_err++; $display("FAIL load_data: got %h required %h", ld0, e.load); end
    n_vec++; if (bus_ok !== 1'b1) begin n_err++; $display("FAIL bus_stable_busy: got %b required 1", bus_ok); end
    n_vec++; if (extra_req !== 0 || extra_done !== 0) begin
      n_err++; $display("FAIL after_done: got req=%0d done=%0d required 0/0", extra_req, extra_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ctrl = 7'h00; base = '0; offset = '0; sdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    n_vec++; if ({busy, done, err, wb_en, mem_req, mem_we, mem_be} !== 10'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b required 0", {busy, done, err, wb_en, mem_req, mem_we, mem_be});
    end
    n_vec++; if ({load_data, wb_addr, mem_addr, mem_wdata} !== 128'b0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h %h required 0", load_data, wb_addr, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    exp_t e;
    e = '{32'h104, 4'b1111, 1'b0, 32'h0, 1, 2, 1'b0, 1'b0, 32'h104, 32'hDEADBEEF};
    sb_q.push_back(e);
    run_cmd(7'b0001100, 32'h100, 32'h4, 32'h0, 0, 32'hDEADBEEF, -1);
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    repeat (3) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || busy !== 1'b0 || load_data !== 32'hDEADBEEF) begin
        n_err++; $display("FAIL ack_in_idle: got done=%b busy=%b load=%h required 0 0 deadbeef", done, busy, load_data);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_byte_store();
    exp_t e;
    e = '{32'h200, 4'b1000, 1'b1, 32'hA5A5A5A5, 2, 3, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF};
    sb_q.push_back(e);
    run_cmd(7'b1010001, 32'h203, 32'h3, 32'h000000A5, 1, 32'h7777_7777, -1);
    n_vec++; if (load_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL store_keeps_load: got %h required deadbeef", load_data);
    end
  endtask

  task automatic test_half_loads();
    exp_t e;
    e = '{32'h300, 4'b1100, 1'b0, 32'h0, 4, 5, 1'b0, 1'b0, 32'h302, 32'h00001234};
    sb_q.push_back(e);
    run_cmd(7'b0101100, 32'h300, 32'h2, 32'h0, 3, 32'h1234ABCD, -1);
    e = '{32'h600, 4'b1100, 1'b0, 32'h0, 1, 2, 1'b0, 1'b0, 32'h603, 32'h00001234};
    sb_q.push_back(e);
    run_cmd(7'b0101100, 32'h600, 32'h3, 32'h0, 0, 32'h1234ABCD, -1);
  endtask

  task automatic test_unaligned_word();
    exp_t e;
    e = '{32'h400, 4'b1111, 1'b0, 32'h0, 1, 2, 1'b0, 1'b0, 32'h401, 32'h44112233};
    sb_q.push_back(e);
    run_cmd(7'b0001100, 32'h400, 32'h1, 32'h0, 0, 32'h11223344, -1);
  endtask

  task automatic test_forward_store();
    exp_t e;
    // halfword store sourced from LOAD_DATA (0x44112233); START also pulsed in FINISH
    e = '{32'h500, 4'b1100, 1'b1, 32'h22332233, 1, 2, 1'b0, 1'b0, 32'h502, 32'h44112233};
    sb_q.push_back(e);
    run_cmd(7'b0111110, 32'h500, 32'h2, 32'hFFFF_FFFF, 0, 32'h0, 2);
  endtask

  task automatic test_timeout();
    exp_t e;
    e = '{32'h910, 4'b1111, 1'b0, 32'h0, 16, 17, 1'b1, 1'b0, 32'h910, 32'h44112233};
    sb_q.push_back(e);
    run_cmd(7'b0001101, 32'h900, 32'h10, 32'h0, -1, 32'h0, 3);
  endtask

  task automatic test_byte_wrap();
    exp_t e;
    e = '{32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 2, 3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h000000AB};
    sb_q.push_back(e);
    run_cmd(7'b1100101, 32'h1, 32'h2, 32'h0, 1, 32'hAB00CDEF, -1);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    start = 1'b1; ctrl = 7'b0001100; base = 32'h700; offset = 32'h0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL req_before_reset: got %b required 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({mem_req, busy, done, mem_be} !== 7'b0 || load_data !== 32'h0 || wb_addr !== 32'h0) begin
      n_err++; $display("FAIL async_reset: got req=%b busy=%b be=%b load=%h wba=%h required zeros",
                        mem_req, busy, mem_be, load_data, wb_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || mem_req !== 1'b0) begin
        n_err++; $display("FAIL no_done_after_reset: got done=%b req=%b required 0 0", done, mem_req);
      end
    end
    e = '{32'h808, 4'b1111, 1'b0, 32'h0, 1, 2, 1'b0, 1'b0, 32'h808, 32'hCAFEF00D};
    sb_q.push_back(e);
    run_cmd(7'b0001100, 32'h800, 32'h8, 32'h0, 0, 32'hCAFEF00D, -1);
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_ack_idle();
    test_byte_store();
    test_half_loads();
    test_unaligned_word();
    test_forward_store();
    test_timeout();
    test_byte_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
